// File: rtl/mux_scan_scheduler_pkg.sv
// Shared definitions for the mux scan scheduler.
//   NUM_CH        number of requesters sharing the 4-to-1 mux
//   DWELL_DEFAULT default number of cycles a granted channel owns the mux
//   S_*           FSM state encodings (2-bit)
package mux_scan_scheduler_pkg;

  localparam int NUM_CH        = 4;
  localparam int DWELL_DEFAULT = 50_000_000;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

endpackage

// File: rtl/mux_scan_scheduler_rr_pick_4.sv
// Combinational round-robin picker for four requesters.
//   req  [3:0] in   request vector
//   last [1:0] in   most recently served channel
//   pick [1:0] out  first set request scanning last+1, last+2, ... (mod 4)
//   any        out  at least one request is set
module rr_pick_4
  import mux_scan_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last,
  output logic [1:0]        pick,
  output logic              any
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    pick  = last;
    cand  = last;
    found = 1'b0;
    any   = |req;
    // k=4 wraps back to last itself, so a lone requester re-wins.
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_scheduler.sv
// Time-shares a 4-to-1 1-bit mux between four requesters. A round-robin
// arbiter grants one channel for DWELL cycles, then captures the mux output
// for that channel.
//   CLOCK_50      in   clock, all state on the rising edge
//   reset         in   synchronous active-high reset
//   req     [3:0] in   level-sensitive per-channel request
//   mux_out       in   output of the shared mux
//   sel     [1:0] out  mux select; holds the last owner between grants
//   grant   [3:0] out  one-hot current owner, zero when none
//   sample  [3:0] out  last captured mux_out per channel
//   done          out  one-cycle pulse when a capture completes
//   busy          out  high in GRANT and RELEASE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no owner; arbitrate among pending requests
// S_GRANT   | channel idx owns the mux while the dwell counter runs down
// S_RELEASE | one-cycle bubble separating consecutive owners
module mux_scan_scheduler
  import mux_scan_scheduler_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT,
  parameter int CNT_W = 26
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              mux_out,
  output logic [1:0]        sel,
  output logic [NUM_CH-1:0] grant,
  output logic [NUM_CH-1:0] sample,
  output logic              done,
  output logic              busy
);

  logic [1:0]       state;
  logic [1:0]       idx;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             any;

  rr_pick_4 u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      last   <= 2'd3;
      cnt    <= '0;
      sel    <= 2'd0;
      grant  <= '0;
      sample <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (any) begin
            state <= S_GRANT;
            idx   <= pick;
            sel   <= pick;
            grant <= 4'(1) << pick;
            cnt   <= CNT_W'(DWELL - 1);
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          // A dropped request aborts even on the terminal-count cycle.
          if (!req[idx]) begin
            state <= S_RELEASE;
            grant <= '0;
            last  <= idx;
          end else if (cnt == '0) begin
            state       <= S_RELEASE;
            grant       <= '0;
            last        <= idx;
            sample[idx] <= mux_out;
            done        <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_scheduler.sv
module tb_mux_scan_scheduler;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] grant;
  logic [3:0] sample;
  logic       done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // reference model: owner-centric view of the schedule
  int         m_owner;
  int         m_held;
  int         m_last;
  bit         m_rel;
  bit         m_done;
  logic [3:0] m_sample;
  logic [1:0] m_sel;

  mux_scan_scheduler #(.DWELL(DWELL), .CNT_W(4)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .req      (req),
    .mux_out  (mux_out),
    .sel      (sel),
    .grant    (grant),
    .sample   (sample),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic m, input logic rst);
    m_done = 1'b0;
    if (rst) begin
      m_owner = -1; m_held = 0; m_last = 3; m_rel = 1'b0;
      m_sample = '0; m_sel = '0;
    end else if (m_owner >= 0) begin
      m_held++;
      if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_rel = 1'b1;
      end else if (m_held == DWELL) begin
        m_sample[m_owner] = m;
        m_done = 1'b1;
        m_last = m_owner; m_owner = -1; m_rel = 1'b1;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (r != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && r[c]) begin
          m_owner = c; m_held = 0; m_sel = 2'(c);
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic m, input logic rst);
    logic [3:0] exp_grant;
    reset = rst; req = r; mux_out = m;
    @(posedge clk);
    model_edge(r, m, rst);
    #1;
    exp_grant = (m_owner >= 0) ? 4'(1) << m_owner : 4'd0;
    check_val("grant",  32'(grant),  32'(exp_grant));
    check_val("sel",    32'(sel),    32'(m_sel));
    check_val("sample", 32'(sample), 32'(m_sample));
    check_val("done",   32'(done),   32'(m_done));
    check_val("busy",   32'(busy),   32'((m_owner >= 0) || m_rel));
  endtask

  initial begin
    logic [3:0] r;
    m_owner = -1; m_held = 0; m_last = 3; m_rel = 1'b0;
    m_sample = '0; m_sel = '0; m_done = 1'b0;
    reset = 1'b1; req = 4'hF; mux_out = 1'b0;
    @(negedge clk);

    repeat (3) step(4'hF, 1'b1, 1'b1);

    // single requester ch2, capture a 1
    repeat (8) step(4'b0100, 1'b1, 1'b0);
    check_val("ch2_captured", 32'(sample), 32'h4);
    repeat (2) step(4'b0000, 1'b0, 1'b0);

    // all requesting, mux_out toggling
    for (int i = 0; i < 30; i++) step(4'hF, 1'(i), 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // ch1 dropped after two grant cycles
    repeat (3) step(4'b0010, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);
    repeat (12) step(4'hF, 1'b1, 1'b0);

    // reset mid-grant, then ch3 only
    repeat (3) step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    repeat (8) step(4'h8, 1'b1, 1'b0);

    // two requesters alternate
    for (int i = 0; i < 30; i++) step(4'b1001, 1'(i >> 1), 1'b0);

    // randomized traffic
    r = 4'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) r = 4'($urandom);
      step(r, 1'($urandom), ($urandom_range(199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
